tlc_master_n: RTL and testbench
===============================

// Module: tlc_master_n
// PURPOSE
//  N-direction traffic-light master: picks which direction holds right-of-way.
//  Generalises the fixed 3-way NS/EW/LT master to NDIR directions with:
//  - one configurable priority direction;
//  - round-robin service among the remaining directions;
//  - min-green and max-green limits from one internal cycle timer.
//  Feeds the light-sequencing slave: the slave asserts ok when a change is safe;
//  the master moves dir only while ok=1.
// PARAMETERS
//  NDIR      3   number of directions (>=2)
//  PRIO_DIR  2   index of the priority (left-turn style) direction, < NDIR
//  RST_DIR   0   direction granted after reset, < NDIR
//  TMIN      4   min green, in cycles; priority pre-emption blocked before this
//  TEXP      12  max green, in cycles, while others wait (TMIN <= TEXP, TEXP >= 1)
//  DW        $clog2(NDIR) (min 1)  width of dir
//  TW        $clog2(TEXP+1)        width of the internal timer
// PORTS
//  clk    in   1     clock, rising edge
//  rst    in   1     reset, synchronous, active-high
//  car    in   NDIR  car[i]=1: vehicle waiting/present on direction i (level)
//  ok     in   1     slave ready to accept a direction change this cycle
//  dir    out  DW    currently granted direction (registered)
//  sw     out  1     one-cycle pulse, high in the cycle dir takes a new value
//  tmax   out  1     timer has reached TEXP (combinational from timer reg)
// BEHAVIOUR
//  Reset
//  - rst=1 at a clk edge: dir=RST_DIR, timer=0, sw=0; rst wins over all else.
//  Timer
//  - Clears to 0 on any edge where dir changes.
//  - Otherwise increments each cycle, saturating at TEXP.
//  - tmax = (timer==TEXP).
//  Definitions, with cur = dir:
//  - other = |(car & ~(1<<cur)).
//  - rr = first i with car[i]=1, searching cur+1, cur+2, ... mod NDIR, skipping cur.
//  Decision: evaluated every cycle; applied at the next edge only if ok=1.
//  - cur!=PRIO_DIR, car[PRIO_DIR]=1, timer>=TMIN -> next=PRIO_DIR.
//  - cur!=PRIO_DIR otherwise: if other && (!car[cur] || tmax), next=rr.
//  - cur==PRIO_DIR: if (!car[PRIO_DIR] || tmax) && other, next=rr.
//  - In all other cases next=cur.
//  - ok=0 -> dir, timer progress unaffected by the decision; dir holds.
//  - No requests anywhere -> dir holds indefinitely; timer saturates.
//  - sw registered: sw=1 exactly in the cycle after the edge where next!=cur.
//    Latency ok&condition -> dir change = 1 edge.
//  - car[cur] dropping with no other request: no change, no sw.
//  - rr wraps NDIR-1 -> 0.
//  - rr can land on PRIO_DIR only when PRIO_DIR is requesting (pre-emption then
//    normally wins first).
//  - rst mid-green: immediate return to RST_DIR, no sw pulse.
//  - car bits not synchronised here; caller supplies clk-domain signals.
// TESTING
//  1. Reset: rst 2 cycles, car=0 -> dir=0, sw=0, tmax=0; 13 idle cycles ->
//     tmax=1, dir=0.
//  2. Round-robin: NDIR=4, PRIO_DIR=3, dir=0, car=4'b0110, ok=1, car[0]=0 ->
//     dir 0->1 with sw pulse; then car=4'b0101 -> dir=2, then wraps to 0.
//  3. Max green: dir=0, car=3'b011 held, ok=1 -> dir stays 0 for 12 cycles,
//     switches to 1 on edge after tmax=1; timer restarts at 0.
//  4. Pre-emption: dir=0 at timer=2, car[2] rises -> no change until timer=4
//     (TMIN), then dir=2; dir stays 2 while car[2]=1 until tmax, then round-robin.
//  5. ok gating: switch condition true but ok=0 for 5 cycles -> dir, sw unchanged;
//     ok=1 -> dir changes next edge, sw high 1 cycle.
//  6. Reset mid-operation: dir=2, timer=7, rst=1 -> next cycle dir=0, timer=0,
//     sw=0.

Source files
------------

// File: rtl/tlc_master_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlc_master_n : N-direction traffic-light master (priority + round-robin)
// Rev 1.0
// ----------------------------------------------------------------------------
module tlc_master_n #(
  parameter int NDIR     = 3,
  parameter int PRIO_DIR = 2,
  parameter int RST_DIR  = 0,
  parameter int TMIN     = 4,
  parameter int TEXP     = 12,
  parameter int DW       = (NDIR > 1) ? $clog2(NDIR) : 1,
  parameter int TW       = $clog2(TEXP + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDIR-1:0] car,
  input  logic            ok,
  output logic [DW-1:0]   dir,
  output logic            sw,
  output logic            tmax
);

  logic [TW-1:0]   timer;
  logic [DW-1:0]   rr;
  logic [DW-1:0]   nxt;
  logic [NDIR-1:0] others;
  logic            other;
  logic            at_prio;

  assign tmax    = (timer == TW'(TEXP));
  assign others  = car & ~(NDIR'(1) << dir);
  assign other   = |others;
  assign at_prio = (dir == DW'(PRIO_DIR));

  // Scan downwards so the nearest requester after cur is the last one written.
  always_comb begin
    rr = dir;
    for (int k = NDIR - 1; k >= 1; k--) begin
      if (car[(int'(dir) + k) % NDIR]) rr = DW'((int'(dir) + k) % NDIR);
    end
  end

  always_comb begin
    nxt = dir;
    if (!at_prio && car[PRIO_DIR] && (timer >= TW'(TMIN))) begin
      nxt = DW'(PRIO_DIR);
    end else if (other && (!car[dir] || tmax)) begin
      nxt = rr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir   <= DW'(RST_DIR);
      timer <= '0;
      sw    <= 1'b0;
    end else begin
      sw <= 1'b0;
      if (ok && (nxt != dir)) begin
        dir   <= nxt;
        timer <= '0;
        sw    <= 1'b1;
      end else if (!tmax) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlc_master_n.sv
`default_nettype none
// Testbench for tlc_master_n: a 3-way and a 4-way instance checked every cycle
// against an integer reference model under directed and random stimulus.
module tb_tlc_master_n;

  localparam int TMIN = 4;
  localparam int TEXP = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ok  = 1'b0;
  logic [2:0] car3 = '0;
  logic [3:0] car4 = '0;
  logic [1:0] dir3, dir4;
  logic       sw3, sw4, tmax3, tmax4;

  int n_checks = 0;
  int n_pass   = 0;

  int m_dir[2];
  int m_t[2];
  int m_sw[2];
  int nd[2]  = '{3, 4};
  int pr[2]  = '{2, 3};

  always #5 clk = ~clk;

  tlc_master_n #(.NDIR(3), .PRIO_DIR(2), .RST_DIR(0), .TMIN(TMIN), .TEXP(TEXP)) u3 (
    .clk(clk), .rst(rst), .car(car3), .ok(ok), .dir(dir3), .sw(sw3), .tmax(tmax3));

  tlc_master_n #(.NDIR(4), .PRIO_DIR(3), .RST_DIR(0), .TMIN(TMIN), .TEXP(TEXP)) u4 (
    .clk(clk), .rst(rst), .car(car4), .ok(ok), .dir(dir4), .sw(sw4), .tmax(tmax4));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Choice of next direction from the rules, on plain integers.
  function automatic int next_of(int n, int prio, int cur, int t, logic [3:0] c);
    bit any_other = 0;
    bit at_max    = (t == TEXP);
    for (int i = 0; i < n; i++) if (i != cur && c[i]) any_other = 1;
    if (cur != prio && c[prio] && t >= TMIN) return prio;
    if (any_other && (!c[cur] || at_max)) begin
      for (int k = 1; k < n; k++) if (c[(cur + k) % n]) return (cur + k) % n;
    end
    return cur;
  endfunction

  task automatic step();
    int nx[2];
    logic [3:0] c[2];
    c[0] = {1'b0, car3};
    c[1] = car4;
    for (int i = 0; i < 2; i++) nx[i] = next_of(nd[i], pr[i], m_dir[i], m_t[i], c[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_dir[i] = 0; m_t[i] = 0; m_sw[i] = 0;
      end else if (ok && nx[i] != m_dir[i]) begin
        m_dir[i] = nx[i]; m_t[i] = 0; m_sw[i] = 1;
      end else begin
        m_sw[i] = 0;
        m_t[i]  = (m_t[i] < TEXP) ? m_t[i] + 1 : TEXP;
      end
    end
    check("dir3",  int'(dir3),  m_dir[0]);
    check("sw3",   int'(sw3),   m_sw[0]);
    check("tmax3", int'(tmax3), int'(m_t[0] == TEXP));
    check("dir4",  int'(dir4),  m_dir[1]);
    check("sw4",   int'(sw4),   m_sw[1]);
    check("tmax4", int'(tmax4), int'(m_t[1] == TEXP));
  endtask

  initial begin
    // Reset, then idle until the timer saturates.
    rst = 1'b1; car3 = '0; car4 = '0; ok = 1'b0;
    step(); step();
    check("reset_dir", int'(dir3), 0);
    rst = 1'b0; ok = 1'b1;
    repeat (13) step();
    check("idle_tmax", int'(tmax3), 1);

    // Max-green: own and neighbour requesting; move after the saturated timer.
    rst = 1'b1; step(); rst = 1'b0;
    car3 = 3'b011; car4 = 4'b0011;
    repeat (16) step();

    // Pre-emption by the priority direction partway through a green.
    rst = 1'b1; step(); rst = 1'b0;
    car3 = 3'b001; car4 = 4'b0001;
    repeat (2) step();
    car3 = 3'b101; car4 = 4'b1001;
    repeat (20) step();

    // Round-robin wrap on the 4-way instance.
    car3 = 3'b110; car4 = 4'b0110;
    repeat (3) step();
    car4 = 4'b0101;
    repeat (3) step();
    car4 = 4'b0001;
    repeat (3) step();

    // ok held low with a pending switch, then released.
    car3 = 3'b010; car4 = 4'b0010; ok = 1'b0;
    repeat (5) step();
    ok = 1'b1;
    repeat (3) step();

    // Reset in the middle of a green.
    car3 = 3'b100; repeat (9) step();
    rst = 1'b1; step(); rst = 1'b0; step();

    // Random traffic with occasional ok drops and resets.
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) begin
        car3 = 3'($urandom);
        car4 = 4'($urandom);
      end
      ok  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
